// File: rtl/tank_game_pkg.sv
// tank_game_pkg: shared sizes and player FSM state encoding for the tank game blocks
package tank_game_pkg;
  localparam int NUM_ENEMY = 4;
  localparam int SCORE_W   = 5;
  localparam int SCORE_MAX = 31;
  localparam int LIVES_W   = 3;
  typedef enum logic [1:0] {ALIVE, HIT, RESPAWN, DEAD} player_state_t;
endpackage

// File: rtl/hit_edge_detect.sv
// hit_edge_detect: rising-edge pulse on one hit level; TANK_HIT_SYNC_EN adds a 2-flop synchroniser
module hit_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic pulse
);
  logic s, prev;
`ifdef TANK_HIT_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= clr ? 2'b00 : {sync[0], d};
  assign s = sync[1];
`else
  assign s = d;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= 1'b0;
    else prev <= clr ? 1'b0 : s;
  assign pulse = s & ~prev;
endmodule

// File: rtl/tank_hit_tracker.sv
// tank_hit_tracker: per-enemy kill scores, enemy respawn timers and player hit/respawn/lives FSM
// Optional TANK_HIT_SYNC_EN synchronises the hit inputs (2 extra cycles of latency).
module tank_hit_tracker
  import tank_game_pkg::*;
#(
  parameter int LIVES        = 5,
  parameter int HIT_HOLD     = 4,
  parameter int RESPAWN_CYC  = 1024,
  parameter int ENY_RESP_CYC = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 game_en,
  input  logic [NUM_ENEMY-1:0] eny_hit,
  input  logic                 player_hit,
  output logic [SCORE_W-1:0]   scorea,
  output logic [SCORE_W-1:0]   scoreb,
  output logic [SCORE_W-1:0]   scorec,
  output logic [SCORE_W-1:0]   scored,
  output logic                 mytank_state,
  output logic [NUM_ENEMY-1:0] enemy_alive,
  output logic [LIVES_W-1:0]   lives,
  output logic                 invuln,
  output logic                 game_over
);
  localparam int CNT_MAX = HIT_HOLD > RESPAWN_CYC ? HIT_HOLD : RESPAWN_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ETM_W   = $clog2(ENY_RESP_CYC + 1);
  logic [NUM_ENEMY-1:0] eny_ev;
  logic                 ply_ev;
  logic [SCORE_W-1:0]   score [NUM_ENEMY];
  hit_edge_detect u_ply (.clk(clk), .rst_n(rst_n), .clr(~game_en), .d(player_hit), .pulse(ply_ev));
  for (genvar i = 0; i < NUM_ENEMY; i++) begin : g_eny
    logic [ETM_W-1:0]   tmr;
    logic [SCORE_W-1:0] sc;
    logic               alive;
    hit_edge_detect u_det (.clk(clk), .rst_n(rst_n), .clr(~game_en), .d(eny_hit[i]), .pulse(eny_ev[i]));
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        sc    <= '0;
        alive <= 1'b1;
        tmr   <= '0;
      end else if (!game_en) begin
        sc    <= '0;
        alive <= 1'b1;
        tmr   <= '0;
      end else if (alive) begin
        if (eny_ev[i]) begin
          if (sc != SCORE_W'(SCORE_MAX)) sc <= sc + 1'b1;
          alive <= 1'b0;
          tmr   <= ETM_W'(ENY_RESP_CYC - 1);
        end
      end else if (tmr == '0) alive <= 1'b1;
      else tmr <= tmr - 1'b1;
    assign score[i]       = sc;
    assign enemy_alive[i] = alive;
  end
  assign scorea = score[0];
  assign scoreb = score[1];
  assign scorec = score[2];
  assign scored = score[3];
  player_state_t      st, st_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [LIVES_W-1:0] lives_nx;
  logic               mt_nx, inv_nx, go_nx;
  always_comb begin
    st_nx    = st;
    cnt_nx   = cnt;
    lives_nx = lives;
    mt_nx    = mytank_state;
    inv_nx   = invuln;
    go_nx    = game_over;
    case (st)
      ALIVE: if (ply_ev && lives != '0) begin
        lives_nx = lives - 1'b1;
        mt_nx    = 1'b0;
        if (lives == LIVES_W'(1)) begin
          st_nx = DEAD;
          go_nx = 1'b1;
        end else begin
          st_nx  = HIT;
          cnt_nx = CNT_W'(HIT_HOLD - 1);
        end
      end
      HIT: if (cnt == '0) begin
        st_nx  = RESPAWN;
        mt_nx  = 1'b1;
        inv_nx = 1'b1;
        cnt_nx = CNT_W'(RESPAWN_CYC - 1);
      end else cnt_nx = cnt - 1'b1;
      RESPAWN: if (cnt == '0) begin
        st_nx  = ALIVE;
        inv_nx = 1'b0;
      end else cnt_nx = cnt - 1'b1;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || !game_en) begin
      st           <= ALIVE;
      cnt          <= '0;
      lives        <= LIVES_W'(LIVES);
      mytank_state <= 1'b1;
      invuln       <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      st           <= st_nx;
      cnt          <= cnt_nx;
      lives        <= lives_nx;
      mytank_state <= mt_nx;
      invuln       <= inv_nx;
      game_over    <= go_nx;
    end
endmodule

// File: tb/tb_tank_hit_tracker.sv
// tb_tank_hit_tracker: directed stimulus with a cycle-stamped expectation queue checked by a monitor
module tb_tank_hit_tracker;
`ifdef TANK_HIT_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif
  logic       clk = 1'b0, rst_n, game_en, player_hit;
  logic [3:0] eny_hit, enemy_alive;
  logic [4:0] scorea, scoreb, scorec, scored;
  logic       mytank_state, invuln, game_over;
  logic [2:0] lives;
  int cyc = 0, vectors = 0, miscompares = 0;
  typedef struct {int c; int sel; int val; string nm;} exp_t;
  exp_t q[$];

  tank_hit_tracker #(.LIVES(5), .HIT_HOLD(4), .RESPAWN_CYC(8), .ENY_RESP_CYC(6)) dut (
    .clk(clk), .rst_n(rst_n), .game_en(game_en), .eny_hit(eny_hit), .player_hit(player_hit),
    .scorea(scorea), .scoreb(scoreb), .scorec(scorec), .scored(scored),
    .mytank_state(mytank_state), .enemy_alive(enemy_alive), .lives(lives),
    .invuln(invuln), .game_over(game_over));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get(int sel);
    case (sel)
      0: return int'(scorea);
      1: return int'(scoreb);
      2: return int'(scorec);
      3: return int'(scored);
      4: return int'(enemy_alive);
      5: return int'(mytank_state);
      6: return int'(lives);
      7: return int'(invuln);
      default: return int'(game_over);
    endcase
  endfunction

  task automatic chk(string nm, int act, int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, want);
    end
  endtask

  task automatic push(int c, int sel, int val, string nm);
    q.push_back('{c, sel, val, nm});
  endtask

  task automatic exp_reset(int c);
    push(c, 0, 0, "rst_scorea");
    push(c, 1, 0, "rst_scoreb");
    push(c, 2, 0, "rst_scorec");
    push(c, 3, 0, "rst_scored");
    push(c, 4, 15, "rst_alive");
    push(c, 5, 1, "rst_mytank");
    push(c, 6, 5, "rst_lives");
    push(c, 7, 0, "rst_invuln");
    push(c, 8, 0, "rst_game_over");
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  always @(negedge clk)
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].c == cyc) begin
        chk(q[i].nm, get(q[i].sel), q[i].val);
        q.delete(i);
      end

  initial begin
    int n, sa, lv;
    rst_n = 1'b0; game_en = 1'b1; eny_hit = 4'h0; player_hit = 1'b0;
    tick(3);
    rst_n = 1'b1;
    exp_reset(cyc + 1);
    exp_reset(cyc + 3);
    tick(4);
    // enemy c held high: one kill, dead for 6 cycles
    n = cyc; eny_hit[2] = 1'b1;
    push(n + L, 2, 1, "t1_scorec");
    push(n + L, 4, 4'hB, "t1_alive_dead");
    push(n + L + 5, 4, 4'hB, "t1_alive_still_dead");
    push(n + L + 6, 4, 4'hF, "t1_alive_back");
    push(n + L + 8, 2, 1, "t1_scorec_held");
    tick(10); eny_hit = 4'h0; tick(4);
    // all enemies in one cycle
    n = cyc; eny_hit = 4'hF;
    push(n + L, 0, 1, "t2_scorea");
    push(n + L, 1, 1, "t2_scoreb");
    push(n + L, 2, 2, "t2_scorec");
    push(n + L, 3, 1, "t2_scored");
    push(n + L, 4, 0, "t2_alive");
    push(n + L + 6, 4, 4'hF, "t2_alive_back");
    tick(); eny_hit = 4'h0; tick(10);
    // saturation of scorea
    sa = 1;
    for (int k = 0; k < 40; k++) begin
      n = cyc; eny_hit[0] = 1'b1;
      sa = sa < 31 ? sa + 1 : 31;
      push(n + L, 0, sa, "t3_scorea_sat");
      tick(); eny_hit[0] = 1'b0; tick(7);
    end
    tick(8);
    // player hit, hold, respawn, ignored second hit
    n = cyc; player_hit = 1'b1;
    push(n + L, 5, 0, "t4_mytank_low");
    push(n + L, 6, 4, "t4_lives");
    push(n + L, 7, 0, "t4_invuln_off");
    push(n + L + 3, 5, 0, "t4_mytank_low_last");
    push(n + L + 4, 5, 1, "t4_mytank_back");
    push(n + L + 4, 7, 1, "t4_invuln_on");
    push(n + L + 11, 7, 1, "t4_invuln_last");
    push(n + L + 12, 7, 0, "t4_invuln_end");
    push(n + L + 12, 5, 1, "t4_mytank_alive");
    tick(); player_hit = 1'b0; tick(6);
    player_hit = 1'b1;
    push(n + L + 8, 6, 4, "t4_invuln_hit_lives");
    push(n + L + 8, 5, 1, "t4_invuln_hit_mytank");
    push(n + L + 9, 7, 1, "t4_invuln_hit_invuln");
    tick(); player_hit = 1'b0; tick(16);
    // lose remaining lives
    lv = 4;
    for (int k = 0; k < 4; k++) begin
      n = cyc; player_hit = 1'b1; lv--;
      push(n + L, 6, lv, "t5_lives");
      push(n + L, 8, lv == 0 ? 1 : 0, "t5_game_over");
      push(n + L + 1, 5, 0, "t5_mytank");
      tick(); player_hit = 1'b0; tick(19);
    end
    n = cyc; player_hit = 1'b1; eny_hit[1] = 1'b1;
    push(n + L, 1, 2, "t5_dead_scoreb");
    push(n + L + 2, 6, 0, "t5_dead_lives");
    push(n + L + 2, 8, 1, "t5_dead_game_over");
    push(n + L + 2, 5, 0, "t5_dead_mytank");
    push(n + L + 2, 7, 0, "t5_dead_invuln");
    tick(); player_hit = 1'b0; eny_hit = 4'h0; tick(8);
    // game_en clears, then drop mid-RESPAWN
    n = cyc; game_en = 1'b0;
    exp_reset(n + 1);
    tick(); game_en = 1'b1;
    exp_reset(n + 3);
    tick(3);
    n = cyc; player_hit = 1'b1;
    tick(); player_hit = 1'b0; tick(L + 5);
    n = cyc;
    push(n, 7, 1, "t6_in_respawn");
    game_en = 1'b0;
    exp_reset(n + 1);
    tick(); game_en = 1'b1; tick(3);
    // async reset mid-HIT
    n = cyc; player_hit = 1'b1;
    push(n + L, 5, 0, "t7_hit_mytank");
    push(n + L, 6, 4, "t7_hit_lives");
    tick(); player_hit = 1'b0; tick(L);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_async_mytank", int'(mytank_state), 1);
    chk("t7_async_lives", int'(lives), 5);
    chk("t7_async_invuln", int'(invuln), 0);
    chk("t7_async_alive", int'(enemy_alive), 15);
    tick(2); rst_n = 1'b1;
    exp_reset(cyc + 1);
    tick(5);
    foreach (q[i]) begin
      miscompares++;
      $display("FAIL %s never checked (due cyc=%0d)", q[i].nm, q[i].c);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
